// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port zero-delay RAM between the fetch port
// and the load/store port. Round-robin grant, sub-word stores turned into
// read-modify-write, registered read data with a one-cycle acknowledge.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no RAM access; arbitrate between eligible requesters
// IREAD  | fetch word read, captured into IData
// DREAD  | data word read, captured into DRData
// DWRITE | full word store straight from DWData
// RMW_RD | read the target word into the merge register
// RMW_WR | write the merge register with the new byte/half lane
// DERR   | misaligned or illegal-size data access, no RAM access
module ram_arbiter #(
    parameter int dataW       = 32,
    parameter int RAMAddrSize = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   IReq,
    input  logic [RAMAddrSize-1:0] IAddr,
    output logic                   IAck,
    output logic [dataW-1:0]       IData,
    input  logic                   DReq,
    input  logic [RAMAddrSize-1:0] DAddr,
    input  logic                   DWrite,
    input  logic [1:0]             DSize,
    input  logic [dataW-1:0]       DWData,
    output logic                   DAck,
    output logic                   DErr,
    output logic [dataW-1:0]       DRData,
    output logic [RAMAddrSize-1:0] RAMAddr,
    output logic [dataW-1:0]       DataIn,
    output logic                   RAMWriteControl,
    input  logic [dataW-1:0]       RAMOut
);

    typedef enum logic [2:0] {
        IDLE, IREAD, DREAD, DWRITE, RMW_RD, RMW_WR, DERR
    } state_t;

    state_t           state_q, state_d;
    logic             last_d;
    logic             grant_i, grant_d;
    logic             i_elig, d_elig;
    logic             d_bad;
    logic [dataW-1:0] merge_q;
    logic [dataW-1:0] merge_word;
    logic [RAMAddrSize-1:0] i_word_addr, d_word_addr;

    // Fetch address bits [1:0] only select bytes inside the word the core extracts itself.
    logic unused_iaddr_lsb;
    assign unused_iaddr_lsb = ^IAddr[1:0];

    assign i_word_addr = {IAddr[RAMAddrSize-1:2], 2'b00};
    assign d_word_addr = {DAddr[RAMAddrSize-1:2], 2'b00};

    // A port is not eligible in its own Ack cycle, so held-high Req is not double-served.
    assign i_elig = IReq && !IAck;
    assign d_elig = DReq && !DAck;
    assign grant_i = (state_q == IDLE) && i_elig && (!d_elig || last_d);
    assign grant_d = (state_q == IDLE) && d_elig && (!i_elig || !last_d);

    assign d_bad = (DSize == 2'b11) ||
                   (DSize == 2'b01 && DAddr[0]) ||
                   (DSize == 2'b10 && DAddr[1:0] != 2'b00);

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_i)
                    state_d = IREAD;
                else if (grant_d) begin
                    if (d_bad)
                        state_d = DERR;
                    else if (!DWrite)
                        state_d = DREAD;
                    else if (DSize == 2'b10)
                        state_d = DWRITE;
                    else
                        state_d = RMW_RD;
                end
            end
            RMW_RD:  state_d = RMW_WR;
            default: state_d = IDLE;
        endcase
    end

    // Merge the new byte/half lane into the word read during RMW_RD
    always_comb begin
        merge_word = merge_q;
        if (DSize == 2'b00)
            merge_word[{DAddr[1:0], 3'b000} +: 8] = DWData[7:0];
        else
            merge_word[{DAddr[1], 4'b0000} +: 16] = DWData[15:0];
    end

    // RAM drive is decoded from state so an async reset kills a write at once
    always_comb begin
        RAMAddr         = '0;
        DataIn          = '0;
        RAMWriteControl = 1'b0;
        case (state_q)
            IREAD:         RAMAddr = i_word_addr;
            DREAD, RMW_RD: RAMAddr = d_word_addr;
            DWRITE: begin
                RAMAddr         = d_word_addr;
                DataIn          = DWData;
                RAMWriteControl = 1'b1;
            end
            RMW_WR: begin
                RAMAddr         = d_word_addr;
                DataIn          = merge_word;
                RAMWriteControl = 1'b1;
            end
            default: ;
        endcase
    end

    // State register and round-robin history; lastD starts at 1 so fetch wins the first tie
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_d  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (grant_i || grant_d)
                last_d <= grant_d;
        end
    end

    // Registered acknowledges, read data and merge register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            IAck    <= 1'b0;
            DAck    <= 1'b0;
            DErr    <= 1'b0;
            IData   <= '0;
            DRData  <= '0;
            merge_q <= '0;
        end else begin
            IAck <= (state_q == IREAD);
            DAck <= (state_q == DREAD) || (state_q == DWRITE) ||
                    (state_q == RMW_WR) || (state_q == DERR);
            DErr <= (state_q == DERR);
            if (state_q == IREAD)
                IData <= RAMOut;
            if (state_q == DREAD)
                DRData <= RAMOut;
            if (state_q == RMW_RD)
                merge_q <= RAMOut;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors against ram_arbiter with a behavioural
// zero-delay RAM; expected values are worked out by hand.
module tb_ram_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        IReq, DReq, DWrite;
    logic [31:0] IAddr, DAddr, DWData;
    logic [1:0]  DSize;
    logic        IAck, DAck, DErr, RAMWriteControl;
    logic [31:0] IData, DRData, RAMAddr, DataIn, RAMOut;

    logic [31:0] mem [0:63];
    logic        pre_we;
    logic [5:0]  pre_addr;
    logic [31:0] pre_data;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat;
    logic err, we_seen;
    logic [31:0] acc_addr;

    ram_arbiter #(.dataW(32), .RAMAddrSize(32)) dut (
        .clock(clock), .reset(reset),
        .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IData(IData),
        .DReq(DReq), .DAddr(DAddr), .DWrite(DWrite), .DSize(DSize), .DWData(DWData),
        .DAck(DAck), .DErr(DErr), .DRData(DRData),
        .RAMAddr(RAMAddr), .DataIn(DataIn), .RAMWriteControl(RAMWriteControl),
        .RAMOut(RAMOut)
    );

    always #5 clock = ~clock;

    assign RAMOut = mem[RAMAddr[7:2]];

    always @(posedge clock) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (RAMWriteControl)
            mem[RAMAddr[7:2]] <= DataIn;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, wanted %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        pre_addr = addr[7:2];
        pre_data = data;
        pre_we   = 1'b1;
        @(posedge clock);
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    // Called at a negedge; returns Ack latency in cycles (0 = no Ack within budget)
    task automatic do_d(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, output int l, output logic e, output logic w);
        l = 0; e = 1'b0; w = 1'b0;
        DWrite = wr; DSize = sz; DAddr = addr; DWData = wd; DReq = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (RAMWriteControl) w = 1'b1;
            if (DAck) begin
                l = k;
                e = DErr;
                break;
            end
        end
        DReq = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_i(input logic [31:0] addr, output int l, output logic [31:0] a);
        l = 0; a = '0;
        IAddr = addr; IReq = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (k == 1) a = RAMAddr;
            if (IAck) begin
                l = k;
                break;
            end
        end
        IReq = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        int n_ack;
        logic any_ram;
        reset = 1'b0;
        IReq = 0; DReq = 0; DWrite = 0; DSize = 2'b10;
        IAddr = '0; DAddr = '0; DWData = '0;
        pre_we = 0; pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge clock);
        chk("rst_iack",  32'(IAck), 0);
        chk("rst_dack",  32'(DAck), 0);
        chk("rst_derr",  32'(DErr), 0);
        chk("rst_idata", IData, 0);
        chk("rst_drdata", DRData, 0);
        chk("rst_ramaddr", RAMAddr, 0);
        chk("rst_datain", DataIn, 0);
        chk("rst_we", 32'(RAMWriteControl), 0);
        reset = 1'b1;
        @(negedge clock);

        // word store then load
        do_d(1'b1, 2'b10, 32'd8, 32'd55, lat, err, we_seen);
        chk("wst_lat", 32'(lat), 2);
        chk("wst_err", 32'(err), 0);
        chk("wst_we",  32'(we_seen), 1);
        chk("wst_mem", mem[2], 32'd55);
        do_d(1'b0, 2'b10, 32'd8, 32'd0, lat, err, we_seen);
        chk("wld_lat", 32'(lat), 2);
        chk("wld_data", DRData, 32'd55);
        chk("wld_err", 32'(err), 0);
        chk("wld_we",  32'(we_seen), 0);

        // sub-word read-modify-write; upper store bits must be ignored
        preload(32'd64, 32'h1122_3344);
        do_d(1'b1, 2'b00, 32'd66, 32'h1234_56AA, lat, err, we_seen);
        chk("bst_lat", 32'(lat), 3);
        chk("bst_err", 32'(err), 0);
        do_d(1'b0, 2'b10, 32'd64, 32'd0, lat, err, we_seen);
        chk("bst_rd", DRData, 32'h11AA_3344);
        do_d(1'b1, 2'b00, 32'd65, 32'h0000_0077, lat, err, we_seen);
        chk("bst1_mem", mem[16], 32'h11AA_7744);
        do_d(1'b1, 2'b01, 32'd66, 32'hDEAD_BEEF, lat, err, we_seen);
        chk("hst_lat", 32'(lat), 3);
        do_d(1'b0, 2'b10, 32'd64, 32'd0, lat, err, we_seen);
        chk("hst_rd", DRData, 32'hBEEF_7744);
        do_d(1'b1, 2'b01, 32'd64, 32'h0000_3344, lat, err, we_seen);
        do_d(1'b0, 2'b10, 32'd64, 32'd0, lat, err, we_seen);
        chk("hst_lo_rd", DRData, 32'hBEEF_3344);

        // error cases: no RAM write, DRData untouched
        do_d(1'b0, 2'b10, 32'd69, 32'd0, lat, err, we_seen);
        chk("mis_lat", 32'(lat), 2);
        chk("mis_err", 32'(err), 1);
        chk("mis_drdata", DRData, 32'hBEEF_3344);
        do_d(1'b1, 2'b01, 32'd65, 32'hFFFF_FFFF, lat, err, we_seen);
        chk("mish_err", 32'(err), 1);
        chk("mish_we",  32'(we_seen), 0);
        chk("mish_mem", mem[16], 32'hBEEF_3344);
        do_d(1'b1, 2'b11, 32'd64, 32'hFFFF_FFFF, lat, err, we_seen);
        chk("sz11_err", 32'(err), 1);
        chk("sz11_we",  32'(we_seen), 0);

        // fetch at an unaligned byte address reads the aligned word
        do_i(32'h43, lat, acc_addr);
        chk("if_lat", 32'(lat), 2);
        chk("if_addr", acc_addr, 32'h40);
        chk("if_data", IData, 32'hBEEF_3344);

        // contention from reset: I, D, I, D
        reset = 1'b0;
        IAddr = 32'h40; DAddr = 32'd8; DWrite = 1'b0; DSize = 2'b10;
        IReq = 1'b1; DReq = 1'b1;
        @(negedge clock);
        chk("rst2_idata", IData, 0);
        reset = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (c % 2 == 1) begin
                chk($sformatf("ct%0d_addr", c), RAMAddr, (c % 4 == 1) ? 32'h40 : 32'd8);
                chk($sformatf("ct%0d_acks", c), {30'd0, IAck, DAck}, 0);
            end else begin
                chk($sformatf("ct%0d_acks", c), {30'd0, IAck, DAck}, (c % 4 == 2) ? 32'd2 : 32'd1);
            end
        end
        IReq = 1'b0; DReq = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("ct_idata", IData, 32'hBEEF_3344);
        chk("ct_drdata", DRData, 32'd55);

        // reset in the middle of a byte RMW
        preload(32'd68, 32'd91);
        DWrite = 1'b1; DSize = 2'b00; DAddr = 32'd68; DWData = 32'hEE; DReq = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("rmw_rd_addr", RAMAddr, 32'd68);
        reset = 1'b0;
        DReq  = 1'b0;
        #1;
        chk("mr_addr", RAMAddr, 0);
        chk("mr_datain", DataIn, 0);
        chk("mr_we", 32'(RAMWriteControl), 0);
        chk("mr_drdata", DRData, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        n_ack = 0;
        repeat (5) begin
            @(posedge clock);
            @(negedge clock);
            if (DAck) n_ack++;
        end
        chk("mr_noack", 32'(n_ack), 0);
        chk("mr_mem", mem[17], 32'd91);
        do_d(1'b0, 2'b10, 32'd68, 32'd0, lat, err, we_seen);
        chk("mr_rd", DRData, 32'd91);

        // idle
        n_ack = 0;
        any_ram = 1'b0;
        repeat (10) begin
            @(posedge clock);
            @(negedge clock);
            if (IAck || DAck) n_ack++;
            if (RAMAddr != 0 || DataIn != 0 || RAMWriteControl) any_ram = 1'b1;
        end
        chk("idle_acks", 32'(n_ack), 0);
        chk("idle_ram", 32'(any_ram), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter and access sequencer that shares the single-port `zeroDelayRAM` between the RV32I core's instruction-fetch port and its load/store port. It grants the RAM round-robin. It converts byte and halfword stores into read-modify-write sequences, because the RAM has no byte enables. It returns registered read data with a single-cycle acknowledge. It sits between the core's fetch/LSU units and the RAM instance.

## Interface
- `dataW`, 32, data word width; must be 32, because the sub-word lane logic assumes 4 bytes.
- `RAMAddrSize`, 32, byte-address width on all address ports.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `IReq`  in  1  fetch request; held high until `IAck`.
- `IAddr`  in  RAMAddrSize  fetch byte address; bits [1:0] are ignored.
- `IAck`  out  1  one-cycle pulse; `IData` is valid this cycle.
- `IData`  out  dataW  fetched word, registered.
- `DReq`  in  1  data request; held high until `DAck`.
- `DAddr`  in  RAMAddrSize  data byte address.
- `DWrite`  in  1  1 = store, 0 = load.
- `DSize`  in  2  00 byte, 01 halfword, 10 word; 11 is illegal.
- `DWData`  in  dataW  store data, right-aligned (byte in [7:0], halfword in [15:0]).
- `DAck`  out  1  one-cycle completion pulse.
- `DErr`  out  1  qualified by `DAck`; misaligned or illegal-size access.
- `DRData`  out  dataW  full aligned word read, registered; the core extracts and extends.
- `RAMAddr`  out  RAMAddrSize  to the RAM; always word-aligned (`{addr[RAMAddrSize-1:2],2'b00}`).
- `DataIn`  out  dataW  RAM write data.
- `RAMWriteControl`  out  1  RAM write enable; the RAM writes on the rising edge.
- `RAMOut`  in  dataW  RAM read data; combinational, valid in the same cycle as `RAMAddr`.

## Operation
- States: IDLE, IREAD, DREAD, DWRITE, RMW_RD, RMW_WR, DERR.
- IDLE arbitration:
  - Eligible port: `Req`=1 and its `Ack` is not high this cycle.
  - Only one port eligible: grant it.
  - Both eligible: grant the port not granted last, tracked by the `lastD` flag. After reset, `lastD`=1, so fetch wins the first tie.
- Grant to fetch → IREAD.
- Grant to data:
  - Misaligned request (half with `DAddr[0]`=1, word with `DAddr[1:0]`≠0) or `DSize`=11 → DERR.
  - Load → DREAD.
  - Word store → DWRITE.
  - Byte or half store → RMW_RD.
- IREAD: `RAMAddr` = aligned `IAddr`; capture `RAMOut` into `IData`; → IDLE; `IAck`=1 next cycle.
- DREAD: same as IREAD, but captures into `DRData` and pulses `DAck`.
- DWRITE: `DataIn`=`DWData`, `RAMWriteControl`=1; → IDLE; `DAck` next cycle.
- RMW_RD: capture `RAMOut` into the merge register; → RMW_WR.
- RMW_WR: write the merged word; → IDLE; `DAck` next cycle.
  - Byte: lane `DAddr[1:0]` replaced by `DWData[7:0]`.
  - Half: lane `DAddr[1]` (0 = [15:0], 1 = [31:16]) replaced by `DWData[15:0]`.
- DERR: no RAM access; → IDLE; `DAck`=1 and `DErr`=1 next cycle. `DRData` is unchanged.
- `lastD` updates on every grant.
- In IDLE and DERR: `RAMAddr`=0, `DataIn`=0, `RAMWriteControl`=0.
- `RAMWriteControl` is high only in DWRITE and RMW_WR.
- Requester inputs must be stable from `Req` rise through `Ack`; the arbiter does not latch them.

## Timing
- Reset values, applied immediately on `reset`=0: state IDLE, `lastD`=1, `IAck`=`DAck`=`DErr`=0, `IData`=`DRData`=0, merge register 0, all RAM outputs 0.
- Latency, `Req` sampled in IDLE at cycle N:
  - Access cycle N+1, `Ack` at N+2 (read, word store, error).
  - Sub-word store: accesses at N+1 and N+2, `Ack` at N+3.
- `Ack` cycle overlaps IDLE.
  - The other port may be granted in the `Ack` cycle.
  - The same port is not eligible in its own `Ack` cycle.
- Back-to-back contention: grants strictly alternate; each port gets at most one grant per two grants.
- Reset asserted in RMW_RD or RMW_WR: `RAMWriteControl` drops immediately, so no partial or merged write occurs. The pending request is lost with no `Ack`.
- Requests arriving while not in IDLE wait; no queueing beyond `Req` level.

## Test plan
- Word store then load: `DReq`, `DWrite`=1, `DSize`=10, `DAddr`=8, `DWData`=55 → `DAck` at N+2. Then a load from 8 → `DRData`=55, `DErr`=0.
- Byte RMW: word at 64 = 0x11223344; store byte 0xAA at `DAddr`=66 → `DAck` at N+3, then a load from 64 returns 0x11AA3344. Half 0xBEEF at 66 → 0xBEEF3344.
- Contention: `IReq` and `DReq` high together from reset, each re-requesting after `Ack` → grant order I, D, I, D. `IAck`/`DAck` alternate every 2 cycles. `RAMAddr` alternates between the two aligned addresses.
- Misalignment: word load at `DAddr`=69 → `DAck`=`DErr`=1 at N+2, `RAMWriteControl` never high, `DRData` unchanged. Fetch at `IAddr`=0x43 reads word 0x40.
- Reset mid-RMW: byte store to 68 (word = 91), drop `reset` during RMW_RD → all outputs 0 immediately. After release, word 68 still reads 91 and no `DAck` is issued.
- Idle: no requests for 10 cycles → RAM outputs all 0, no `Ack` pulses.
